// File: rtl/extract_metadata_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : extract_metadata_mc_if
//  Description : AXI4-Stream bundle (tdata/tstrb/tuser/tvalid/tready/tlast)
//                used for both the RX input and the output of
//                extract_metadata_mc.
//  Modports    : master - drives tdata/tstrb/tuser/tvalid/tlast, takes tready
//                slave  - takes tdata/tstrb/tuser/tvalid/tlast, drives tready
//  Revision    : 1.0 - initial release
// ============================================================================
interface extract_metadata_mc_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (
    output tdata,
    output tstrb,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/extract_metadata_mc.sv
`default_nettype none
// ============================================================================
//  Module      : extract_metadata_mc
//  Description : RX-path metadata extractor. When extraction is enabled the
//                first beat of each packet is a metadata header; it is
//                stripped and its timestamp (and optionally its length field)
//                is overlaid onto the tuser of the payload beats. With
//                extraction disabled packets pass through unmodified. All
//                traffic goes through a small first-word-fallthrough FIFO.
//  Ports       : axi_aclk        clock
//                axi_areset      synchronous active-high reset
//                sw_rst          synchronous active-high soft reset
//                s_axis          AXI4-Stream input  (slave modport)
//                m_axis          AXI4-Stream output (master modport)
//                em_enable       extraction enable, sampled at packet start
//                em_ts_all_beats timestamp on every payload beat (else first)
//                em_len_en       overwrite tuser[15:0] with header length
//                pkt_count       extracted packets completed (wraps)
//                hdr_drop_count  header-only packets dropped (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module extract_metadata_mc #(
  parameter int C_AXIS_DATA_WIDTH     = 512,
  parameter int C_AXIS_TUSER_WIDTH    = 128,
  parameter int C_TS_WIDTH            = 64,
  parameter int C_TUSER_TIMESTAMP_POS = 32,
  parameter int C_LEN_POS             = 64,
  parameter int C_FIFO_DEPTH_BITS     = 2
) (
  input  wire                          axi_aclk,
  input  wire                          axi_areset,
  input  wire                          sw_rst,

  extract_metadata_mc_if.slave         s_axis,
  extract_metadata_mc_if.master        m_axis,

  input  wire                          em_enable,
  input  wire                          em_ts_all_beats,
  input  wire                          em_len_en,

  output logic [31:0]                  pkt_count,
  output logic [31:0]                  hdr_drop_count
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;
  localparam int FIFO_WIDTH = C_AXIS_DATA_WIDTH + STRB_WIDTH + C_AXIS_TUSER_WIDTH + 1;
  localparam int FIFO_DEPTH = 1 << C_FIFO_DEPTH_BITS;

  // Input is throttled one entry before the FIFO is full, so a beat that is
  // already in flight on the same cycle the threshold is reached still fits.
  localparam logic [C_FIFO_DEPTH_BITS:0] NEARLY_FULL_LEVEL =
    (C_FIFO_DEPTH_BITS + 1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_START   = 2'd0,
    S_PAYLOAD = 2'd1,
    S_BYPASS  = 2'd2
  } state_t;

  // Either reset source has identical effect.
  logic rst_any;
  assign rst_any = axi_areset | sw_rst;

  // --------------------------------------------------------------------------
  // Input FIFO (first-word fallthrough)
  // --------------------------------------------------------------------------
  logic [FIFO_WIDTH-1:0]         fifo_mem [FIFO_DEPTH];
  logic [C_FIFO_DEPTH_BITS-1:0]  wr_ptr;
  logic [C_FIFO_DEPTH_BITS-1:0]  rd_ptr;
  logic [C_FIFO_DEPTH_BITS:0]    fifo_count;

  logic                          fifo_empty;
  logic                          fifo_nearly_full;
  logic                          fifo_wr;
  logic                          fifo_rd;

  logic [FIFO_WIDTH-1:0]         head_word;
  logic [C_AXIS_DATA_WIDTH-1:0]  head_tdata;
  logic [STRB_WIDTH-1:0]         head_tstrb;
  logic [C_AXIS_TUSER_WIDTH-1:0] head_tuser;
  logic                          head_tlast;

  assign fifo_empty       = (fifo_count == '0);
  assign fifo_nearly_full = (fifo_count >= NEARLY_FULL_LEVEL);

  // Ready is held low for the whole reset so nothing is written into a FIFO
  // that is being flushed.
  assign s_axis.tready = !fifo_nearly_full && !rst_any;
  assign fifo_wr       = s_axis.tvalid && s_axis.tready;

  assign head_word = fifo_mem[rd_ptr];
  assign {head_tlast, head_tuser, head_tstrb, head_tdata} = head_word;

  // Storage needs no reset: flushing the pointers makes its contents invisible.
  always_ff @(posedge axi_aclk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst_any) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Packet state and per-packet latched configuration
  // --------------------------------------------------------------------------
  state_t                 state;
  logic [C_TS_WIDTH-1:0]  ts_r;
  logic [15:0]            len_r;
  logic                   ts_all_r;
  logic                   len_en_r;
  logic                   first_r;       // next payload beat is the first one
  logic                   bypass_hold_r; // bypass start beat offered, not taken

  // Once a bypass start beat has been offered on the output it must stay
  // offered even if em_enable rises before it is accepted, otherwise the
  // beat would be retracted and reinterpreted as a header.
  logic start_extract;
  assign start_extract = em_enable && !bypass_hold_r;

  // --------------------------------------------------------------------------
  // Output-side decode: valid, FIFO pop and tuser overlay
  // --------------------------------------------------------------------------
  logic                          out_valid;
  logic [C_AXIS_TUSER_WIDTH-1:0] out_tuser;

  always_comb begin
    out_valid = 1'b0;
    fifo_rd   = 1'b0;
    out_tuser = head_tuser;

    if (!rst_any && !fifo_empty) begin
      case (state)
        S_START: begin
          if (start_extract) begin
            // Header is consumed internally and never shown on the output.
            fifo_rd = 1'b1;
          end else begin
            out_valid = 1'b1;
            fifo_rd   = m_axis.tready;
          end
        end
        S_PAYLOAD, S_BYPASS: begin
          out_valid = 1'b1;
          fifo_rd   = m_axis.tready;
        end
        default: begin
          out_valid = 1'b0;
          fifo_rd   = 1'b0;
        end
      endcase
    end

    if (state == S_PAYLOAD) begin
      out_tuser[C_TUSER_TIMESTAMP_POS +: C_TS_WIDTH] =
        (first_r || ts_all_r) ? ts_r : '0;
      if (len_en_r) begin
        out_tuser[15:0] = len_r;
      end
    end
  end

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = head_tdata;
  assign m_axis.tstrb  = head_tstrb;
  assign m_axis.tlast  = head_tlast;
  assign m_axis.tuser  = out_tuser;

  // --------------------------------------------------------------------------
  // State machine and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (rst_any) begin
      state          <= S_START;
      ts_r           <= '0;
      len_r          <= '0;
      ts_all_r       <= 1'b0;
      len_en_r       <= 1'b0;
      first_r        <= 1'b0;
      bypass_hold_r  <= 1'b0;
      pkt_count      <= '0;
      hdr_drop_count <= '0;
    end else if (!fifo_empty) begin
      case (state)
        S_START: begin
          if (start_extract) begin
            ts_r     <= head_tdata[C_TS_WIDTH-1:0];
            len_r    <= head_tdata[C_LEN_POS +: 16];
            ts_all_r <= em_ts_all_beats;
            len_en_r <= em_len_en;
            first_r  <= 1'b1;
            if (head_tlast) begin
              // Header with no payload: malformed, drop it silently.
              hdr_drop_count <= hdr_drop_count + 32'd1;
            end else begin
              state <= S_PAYLOAD;
            end
          end else if (m_axis.tready) begin
            bypass_hold_r <= 1'b0;
            if (!head_tlast) begin
              state <= S_BYPASS;
            end
          end else begin
            bypass_hold_r <= 1'b1;
          end
        end

        S_PAYLOAD: begin
          if (m_axis.tready) begin
            first_r <= 1'b0;
            if (head_tlast) begin
              pkt_count <= pkt_count + 32'd1;
              state     <= S_START;
            end
          end
        end

        S_BYPASS: begin
          if (m_axis.tready && head_tlast) begin
            state <= S_START;
          end
        end

        default: begin
          state <= S_START;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_extract_metadata_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_extract_metadata_mc
//  Description : Directed self-checking bench for extract_metadata_mc with
//                default parameters (512-bit data, 128-bit tuser, 64-bit
//                timestamp at tuser[95:32], length at header tdata[79:64]).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_extract_metadata_mc;

  localparam int DW = 512;
  localparam int UW = 128;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sw_rst = 1'b0;
  logic em_enable = 1'b0;
  logic em_ts_all = 1'b0;
  logic em_len_en = 1'b0;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  extract_metadata_mc_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  extract_metadata_mc_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

  extract_metadata_mc dut (
    .axi_aclk        (clk),
    .axi_areset      (rst),
    .sw_rst          (sw_rst),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .em_enable       (em_enable),
    .em_ts_all_beats (em_ts_all),
    .em_len_en       (em_len_en),
    .pkt_count       (pkt_count),
    .hdr_drop_count  (drop_count)
  );

  // ---------------- output capture and stability watch ----------------
  logic [DW-1:0] q_data [$];
  logic [UW-1:0] q_user [$];
  logic [SW-1:0] q_strb [$];
  logic          q_last [$];
  int            stab_viol = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [UW-1:0] prev_user;
  logic          prev_last;

  always @(negedge clk) begin
    if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data ||
                       m_if.tuser !== prev_user || m_if.tlast !== prev_last))
      stab_viol++;
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      q_data.push_back(m_if.tdata);
      q_user.push_back(m_if.tuser);
      q_strb.push_back(m_if.tstrb);
      q_last.push_back(m_if.tlast);
    end
    prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
    prev_data  = m_if.tdata;
    prev_user  = m_if.tuser;
    prev_last  = m_if.tlast;
  end

  // Random output ready (about 30% duty) while rand_en is set.
  logic rand_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) m_if.tready = ($urandom_range(0, 9) < 3);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] pd(input int k);
    logic [DW-1:0] d = '0;
    logic [31:0] kk = k;
    d[63:0]    = {32'hD0D0_0000, kk};
    d[511:448] = 64'h5A5A_1234_5678_9ABC;
    return d;
  endfunction

  function automatic logic [UW-1:0] tu(input int k);
    logic [31:0] kk = k;
    logic [31:0] hi = 32'hC0DE_0000 + kk;
    logic [15:0] lo = 16'h1234 + kk[15:0];
    return {hi, 64'hFFFF_EEEE_DDDD_CCCC, 16'h0000, lo};
  endfunction

  function automatic logic [DW-1:0] hdr(input logic [63:0] ts, input logic [15:0] len);
    logic [DW-1:0] h = '0;
    h[63:0]    = ts;
    h[79:64]   = len;
    h[95:80]   = 16'h7777;
    h[511:500] = 12'hABC;
    return h;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] u,
                           input logic [SW-1:0] s, input logic l);
    bit done = 0;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tstrb  = s;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (s_if.tready === 1'b1);
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_axis_tready never seen high");
    end
  endtask

  task automatic wait_out(input int n, input int max_cycles);
    for (int i = 0; i < max_cycles && q_data.size() < n; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_user.delete();
    q_strb.delete();
    q_last.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_q();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_if.tready); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL reset_release_tready: got %b want 1", s_if.tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [UW-1:0] exp_u [3];
    logic [SW-1:0] exp_s [3];
    apply_reset();
    em_enable = 1; em_ts_all = 0; em_len_en = 0; m_if.tready = 1;
    exp_u[0] = {32'hC0DE_0000, 64'h0123_4567_89AB_CDEF, 16'h0, 16'h1234};
    exp_u[1] = {32'hC0DE_0001, 64'h0, 16'h0, 16'h1235};
    exp_u[2] = {32'hC0DE_0002, 64'h0, 16'h0, 16'h1236};
    exp_s[0] = '1; exp_s[1] = '1; exp_s[2] = 64'h0000_0000_0000_FFFF;
    send_beat(hdr(64'h0123_4567_89AB_CDEF, 16'h05DC), tu(99), '1, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(pd(i), tu(i), exp_s[i], i == 2);
    wait_out(3, 200);
    checks++; if (q_data.size() !== 3) begin errors++; $display("FAIL basic_count: got %0d want 3", q_data.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      checks++; if (q_data[i] !== pd(i)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, q_data[i][63:0], pd(i) & 64'hFFFF_FFFF_FFFF_FFFF); end
      checks++; if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL basic_tuser[%0d]: got %h want %h", i, q_user[i], exp_u[i]); end
      checks++; if (q_strb[i] !== exp_s[i]) begin errors++; $display("FAIL basic_tstrb[%0d]: got %h want %h", i, q_strb[i], exp_s[i]); end
      checks++; if (q_last[i] !== (i == 2)) begin errors++; $display("FAIL basic_tlast[%0d]: got %b want %b", i, q_last[i], i == 2); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL basic_pkt_count: got %0d want 1", pkt_count); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL basic_drop_count: got %0d want 0", drop_count); end
  endtask

  task automatic test_all_beats_len();
    logic [UW-1:0] exp_u [3];
    apply_reset();
    em_enable = 1; em_ts_all = 1; em_len_en = 1; m_if.tready = 1;
    exp_u[0] = {32'hC0DE_0000, 64'h0123_4567_89AB_CDEF, 16'h0, 16'h05DC};
    exp_u[1] = {32'hC0DE_0001, 64'h0123_4567_89AB_CDEF, 16'h0, 16'h05DC};
    exp_u[2] = {32'hC0DE_0002, 64'h0123_4567_89AB_CDEF, 16'h0, 16'h05DC};
    send_beat(hdr(64'h0123_4567_89AB_CDEF, 16'h05DC), tu(99), '1, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(pd(i), tu(i), '1, i == 2);
    wait_out(3, 200);
    checks++; if (q_data.size() !== 3) begin errors++; $display("FAIL allbeats_count: got %0d want 3", q_data.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      checks++; if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL allbeats_tuser[%0d]: got %h want %h", i, q_user[i], exp_u[i]); end
      checks++; if (q_data[i] !== pd(i)) begin errors++; $display("FAIL allbeats_data[%0d]: low word got %h", i, q_data[i][63:0]); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL allbeats_pkt_count: got %0d want 1", pkt_count); end
  endtask

  task automatic test_hdr_drop();
    logic [UW-1:0] exp_u [2];
    apply_reset();
    em_enable = 1; em_ts_all = 0; em_len_en = 0; m_if.tready = 1;
    exp_u[0] = {32'hC0DE_000A, 64'hFEDC_BA98_7654_3210, 16'h0, 16'h123E};
    exp_u[1] = {32'hC0DE_000B, 64'h0, 16'h0, 16'h123F};
    send_beat(hdr(64'h1111_2222_3333_4444, 16'h0020), tu(98), '1, 1'b1);
    send_beat(hdr(64'hFEDC_BA98_7654_3210, 16'h0040), tu(97), '1, 1'b0);
    send_beat(pd(10), tu(10), '1, 1'b0);
    send_beat(pd(11), tu(11), '1, 1'b1);
    wait_out(2, 200);
    checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL drop_count_out: got %0d beats want 2", q_data.size()); end
    for (int i = 0; i < 2 && i < q_data.size(); i++) begin
      checks++; if (q_data[i] !== pd(10 + i)) begin errors++; $display("FAIL drop_data[%0d]: low word got %h", i, q_data[i][63:0]); end
      checks++; if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL drop_tuser[%0d]: got %h want %h", i, q_user[i], exp_u[i]); end
    end
    checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL drop_hdr_drop_count: got %0d want 1", drop_count); end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL drop_pkt_count: got %0d want 1", pkt_count); end
  endtask

  task automatic test_mode_latch();
    logic [UW-1:0] exp_u [6];
    logic [DW-1:0] exp_d [6];
    apply_reset();
    em_enable = 0; em_ts_all = 0; em_len_en = 0; m_if.tready = 1;
    for (int i = 0; i < 4; i++) begin exp_d[i] = pd(20 + i); exp_u[i] = tu(20 + i); end
    exp_d[4] = pd(24); exp_u[4] = {32'hC0DE_0018, 64'h0000_0000_CAFE_F00D, 16'h0, 16'h124C};
    exp_d[5] = pd(25); exp_u[5] = {32'hC0DE_0019, 64'h0, 16'h0, 16'h124D};
    for (int i = 0; i < 4; i++) begin
      send_beat(pd(20 + i), tu(20 + i), '1, i == 3);
      if (i == 1) em_enable = 1;
    end
    send_beat(hdr(64'h0000_0000_CAFE_F00D, 16'h0010), tu(96), '1, 1'b0);
    send_beat(pd(24), tu(24), '1, 1'b0);
    send_beat(pd(25), tu(25), '1, 1'b1);
    wait_out(6, 200);
    checks++; if (q_data.size() !== 6) begin errors++; $display("FAIL latch_count: got %0d want 6", q_data.size()); end
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      checks++; if (q_data[i] !== exp_d[i]) begin errors++; $display("FAIL latch_data[%0d]: low word got %h", i, q_data[i][63:0]); end
      checks++; if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL latch_tuser[%0d]: got %h want %h", i, q_user[i], exp_u[i]); end
      checks++; if (q_last[i] !== (i == 3 || i == 5)) begin errors++; $display("FAIL latch_tlast[%0d]: got %b", i, q_last[i]); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL latch_pkt_count: got %0d want 1", pkt_count); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [$];
    logic [UW-1:0] exp_u [$];
    logic          exp_l [$];
    logic [UW-1:0] u;
    logic [63:0]   ts;
    int k = 100;
    int bad = 0;
    apply_reset();
    em_enable = 1; em_ts_all = 1; em_len_en = 0;
    stab_viol = 0;
    rand_en = 1;
    for (int p = 0; p < 20; p++) begin
      ts = 64'hA5A5_0000_0000_0000 + 64'(p);
      send_beat(hdr(ts, 16'(p)), tu(500 + p), '1, 1'b0);
      for (int b = 0; b <= p % 3; b++) begin
        send_beat(pd(k), tu(k), '1, b == p % 3);
        u = tu(k);
        u[95:32] = ts;
        exp_d.push_back(pd(k));
        exp_u.push_back(u);
        exp_l.push_back(b == p % 3);
        k++;
      end
    end
    wait_out(exp_d.size(), 3000);
    rand_en = 0;
    m_if.tready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q_data.size() !== exp_d.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", q_data.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < q_data.size(); i++)
      if (q_data[i] !== exp_d[i] || q_user[i] !== exp_u[i] || q_last[i] !== exp_l[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_beats: %0d beats differ, want 0", bad); end
    checks++; if (pkt_count !== 32'd20) begin errors++; $display("FAIL bp_pkt_count: got %0d want 20", pkt_count); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stability: got %0d changes under stall want 0", stab_viol); end
  endtask

  task automatic test_soft_reset();
    logic [UW-1:0] exp_u [2];
    apply_reset();
    em_enable = 1; em_ts_all = 0; em_len_en = 1; m_if.tready = 0;
    exp_u[0] = {32'hC0DE_00C8, 64'h5555_6666_7777_8888, 16'h0, 16'h0100};
    exp_u[1] = {32'hC0DE_00C9, 64'h0, 16'h0, 16'h0100};
    send_beat(hdr(64'h9999_AAAA_BBBB_CCCC, 16'h0033), tu(95), '1, 1'b0);
    send_beat(pd(150), tu(150), '1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL srst_pending_valid: got %b want 1", m_if.tvalid); end
    @(posedge clk);
    #1;
    sw_rst = 1;
    @(negedge clk);
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL srst_tready: got %b want 0", s_if.tready); end
    @(posedge clk);
    #1;
    sw_rst = 0;
    @(negedge clk);
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL srst_fifo_empty: tvalid got %b want 0", m_if.tvalid); end
    @(posedge clk);
    #1;
    clear_q();
    m_if.tready = 1;
    send_beat(hdr(64'h5555_6666_7777_8888, 16'h0100), tu(94), '1, 1'b0);
    send_beat(pd(200), tu(200), '1, 1'b0);
    send_beat(pd(201), tu(201), '1, 1'b1);
    wait_out(2, 200);
    checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL srst_count: got %0d want 2", q_data.size()); end
    for (int i = 0; i < 2 && i < q_data.size(); i++) begin
      checks++; if (q_data[i] !== pd(200 + i)) begin errors++; $display("FAIL srst_data[%0d]: low word got %h", i, q_data[i][63:0]); end
      checks++; if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL srst_tuser[%0d]: got %h want %h", i, q_user[i], exp_u[i]); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL srst_pkt_count: got %0d want 1", pkt_count); end
  endtask

  initial begin
    s_if.tvalid = 0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tstrb  = '0;
    s_if.tlast  = 0;
    m_if.tready = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_all_beats_len();
    test_hdr_drop();
    test_mode_latch();
    test_back_to_back();
    test_soft_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
